control_unit: RTL and testbench
===============================

# control_unit

Main decoder of the single-cycle MIPS datapath. Decodes the 6-bit instruction opcode into the datapath steering signals (register-destination select, ALU source, memory write, write-back select, branch, jump, register write) and a 3-bit ALU operation class for the ALU control stage. All outputs are registered; the block sits between instruction fetch and the datapath/ALU-control logic.

## Interface
- No parameters.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction bits [31:26].
- `Funct` in 6: instruction bits [5:0]; only consulted when `CONTROL_UNIT_ILLEGAL_EN` is defined.
- `ALUOp` out 3: ALU operation class.
- `MemtoReg` out 1: 1 selects memory read data for write-back.
- `MemWrite` out 1: data memory write enable.
- `Branch` out 1: conditional branch (beq).
- `ALUSrc` out 1: 1 selects sign-extended immediate as ALU B operand.
- `RegDst` out 1: 1 selects rd, 0 selects rt as destination.
- `RegWrite` out 1: register file write enable.
- `Jump` out 1: unconditional jump.
- `illegal` out 1: present only with `CONTROL_UNIT_ILLEGAL_EN`.

## Operation
- ALUOp encoding: 000 ADD (address/immediate), 001 SUB (compare), 010 FUNCT (ALU control decodes Funct). Other codes unused.
- Decode (RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, ALUOp):
- R-type 000000: 1,0,0,1,0,0,0,010.
- LW 100011: 0,1,1,1,0,0,0,000.
- SW 101011: 0,1,0,0,1,0,0,000.
- BEQ 000100: 0,0,0,0,0,1,0,001.
- ADDI 001000: 0,1,0,1,0,0,0,000.
- J 000010: 0,0,0,0,0,0,1,000.
- Any other opcode: all control outputs 0, ALUOp=000. No write enable is ever asserted for an undefined opcode.
- Outputs are mutually consistent: at most one of Branch/Jump high; MemWrite and RegWrite never both high.

## Timing
- Outputs registered: values for opcode/Funct sampled at rising edge N appear after edge N, held until edge N+1. Latency exactly 1 cycle; no handshake.
- Reset: at a rising edge with `reset`=1, all outputs (including `ALUOp` and `illegal`) become 0. Reset dominates any opcode.
- Reset deasserted mid-stream: first edge with `reset`=0 loads the decode of the opcode present at that edge.
- Before the first reset edge, output values are undefined.
- Combinational path opcode -> registers only; no combinational path from inputs to outputs.

## Configuration
- `CONTROL_UNIT_ILLEGAL_EN` defined: `illegal` output exists; registered with the same latency; high when opcode is undefined, or opcode=000000 and Funct is not one of 000000 (nop/sll), 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. For illegal R-type, RegWrite is forced to 0 (other R-type fields unchanged).
- Undefined: no `illegal` port, Funct ignored, decode exactly as listed in Operation.

## Structure
- Package `control_unit_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), supported Funct constants, and a packed struct typedef for the control bundle.
- One combinational sub-module `control_unit_decode` (opcode, Funct -> control bundle, illegal); top-level `control_unit` registers the bundle with synchronous reset.

## Test plan
- Reset: assert `reset` one edge with opcode=100011 -> all outputs 0 after that edge.
- R-type: opcode=000000, Funct=000000 -> after one edge RegDst=1, RegWrite=1, ALUOp=010, others 0; `illegal`=0 when enabled.
- Memory: opcode=100011 then 101011 on consecutive edges -> LW row (ALUSrc=1, MemtoReg=1, RegWrite=1, ALUOp=000) then SW row (ALUSrc=1, MemWrite=1, RegWrite=0).
- Control flow: opcode=000100 -> Branch=1, ALUOp=001; then 000010 -> Jump=1, Branch=0, RegWrite=0.
- ADDI then invalid: opcode=001000 -> ALUSrc=1, RegWrite=1, RegDst=0; then 111111 -> all outputs 0, `illegal`=1 when enabled.
- Latency check: change opcode between edges -> outputs unchanged until next rising edge; with feature enabled, opcode=000000, Funct=001000 -> `illegal`=1, RegWrite=0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared constants and control bundle for the MIPS main decoder.
// Optional CONTROL_UNIT_ILLEGAL_EN build adds the Funct legality helper.
package control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic op_defined(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic funct_supported(input logic [5:0] fn);
        return fn inside {FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode decode into the control bundle.
// With CONTROL_UNIT_ILLEGAL_EN, also flags undefined opcodes / R-type functs.
module control_unit_decode
    import control_unit_pkg::*;
(
    input  logic [5:0] i_opcode,
`ifdef CONTROL_UNIT_ILLEGAL_EN
    input  logic [5:0] i_funct,
    output logic       o_illegal,
`endif
    output ctrl_t      o_ctrl
);

    ctrl_t w_base;

    always_comb begin
        w_base = '0;
        unique case (i_opcode)
            OP_RTYPE: begin
                w_base.reg_dst   = 1'b1;
                w_base.reg_write = 1'b1;
                w_base.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_base.alu_src    = 1'b1;
                w_base.mem_to_reg = 1'b1;
                w_base.reg_write  = 1'b1;
                w_base.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                w_base.alu_src   = 1'b1;
                w_base.mem_write = 1'b1;
                w_base.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                w_base.branch = 1'b1;
                w_base.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_base.alu_src   = 1'b1;
                w_base.reg_write = 1'b1;
                w_base.alu_op    = ALUOP_ADD;
            end
            OP_J: begin
                w_base.jump = 1'b1;
            end
            default: w_base = '0;
        endcase
    end

`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic w_bad_rtype;

    assign w_bad_rtype = (i_opcode == OP_RTYPE) && !funct_supported(i_funct);
    assign o_illegal   = !op_defined(i_opcode) || w_bad_rtype;

    // Unsupported R-type keeps its steering but must not commit a write
    always_comb begin
        o_ctrl = w_base;
        if (w_bad_rtype)
            o_ctrl.reg_write = 1'b0;
    end
`else
    assign o_ctrl = w_base;
`endif

endmodule

// File: rtl/control_unit.sv
// Registered MIPS main decoder: one-cycle latency, synchronous reset.
// Define CONTROL_UNIT_ILLEGAL_EN to add the registered illegal output.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] Funct,
    output logic [2:0] ALUOp,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       RegWrite,
`ifdef CONTROL_UNIT_ILLEGAL_EN
    output logic       illegal,
`endif
    output logic       Jump
);

    ctrl_t w_ctrl;
    ctrl_t r_ctrl;

`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic w_illegal;
    logic r_illegal;

    control_unit_decode u_decode (
        .i_opcode  (opcode),
        .i_funct   (Funct),
        .o_illegal (w_illegal),
        .o_ctrl    (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_illegal <= 1'b0;
        else
            r_illegal <= w_illegal;
    end

    assign illegal = r_illegal;
`else
    logic w_unused_funct;

    assign w_unused_funct = ^Funct;

    control_unit_decode u_decode (
        .i_opcode (opcode),
        .o_ctrl   (w_ctrl)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_ctrl <= '0;
        else
            r_ctrl <= w_ctrl;
    end

    assign RegDst   = r_ctrl.reg_dst;
    assign ALUSrc   = r_ctrl.alu_src;
    assign MemtoReg = r_ctrl.mem_to_reg;
    assign RegWrite = r_ctrl.reg_write;
    assign MemWrite = r_ctrl.mem_write;
    assign Branch   = r_ctrl.branch;
    assign Jump     = r_ctrl.jump;
    assign ALUOp    = r_ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: vector table, corner sequences,
// and randomized opcodes against a table-lookup reference model.
module tb_control_unit;

`ifdef CONTROL_UNIT_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] Funct;
    logic [2:0] ALUOp;
    logic       MemtoReg, MemWrite, Branch, ALUSrc;
    logic       RegDst, RegWrite, Jump;
`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic       illegal;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .Funct    (Funct),
        .ALUOp    (ALUOp),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
`ifdef CONTROL_UNIT_ILLEGAL_EN
        .illegal  (illegal),
`endif
        .Jump     (Jump)
    );

    // Rows straight from the decode table:
    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,Jump,ALUOp}
    typedef struct {
        logic [5:0] op;
        logic [9:0] bits;
    } row_t;

    row_t rows [6];
    logic [5:0] legal_fn [6];

    function automatic logic [10:0] ref_model(input logic [5:0] op,
                                              input logic [5:0] fn);
        logic [9:0] c;
        logic       ill;
        logic       fn_ok;
        c   = 10'b0;
        ill = 1'b1;
        for (int i = 0; i < 6; i++)
            if (rows[i].op == op) begin
                c   = rows[i].bits;
                ill = 1'b0;
            end
        fn_ok = 1'b0;
        for (int i = 0; i < 6; i++)
            if (legal_fn[i] == fn) fn_ok = 1'b1;
        if (ILL && op == 6'd0 && !fn_ok) begin
            ill  = 1'b1;
            c[6] = 1'b0;
        end
        return {ill, c};
    endfunction

    task automatic chk(input string nm, input logic [9:0] e, input logic ei);
        logic [9:0] a;
        a = {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite,
             Branch, Jump, ALUOp};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s ctrl got %b want %b (illegal want %b)",
                     nm, a, e, ei);
        end
`ifdef CONTROL_UNIT_ILLEGAL_EN
        checks++;
        if (illegal !== ei) begin
            errors++;
            $display("FAIL %s illegal got %b want %b", nm, illegal, ei);
        end
`endif
        checks++;
        if ((Branch & Jump) | (MemWrite & RegWrite)) begin
            errors++;
            $display("FAIL %s consistency got B%b J%b MW%b RW%b want exclusive",
                     nm, Branch, Jump, MemWrite, RegWrite);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op,
                        input logic [5:0] fn);
        reset  = r;
        opcode = op;
        Funct  = fn;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      nm;
        logic       r;
        logic [5:0] op;
        logic [5:0] fn;
        logic [9:0] e;
        logic       ei;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [10:0] m;
        logic [5:0]  op, fn;
        logic        r;

        rows[0] = '{6'b000000, 10'b1001000010};
        rows[1] = '{6'b100011, 10'b0111000000};
        rows[2] = '{6'b101011, 10'b0100100000};
        rows[3] = '{6'b000100, 10'b0000010001};
        rows[4] = '{6'b001000, 10'b0101000000};
        rows[5] = '{6'b000010, 10'b0000001000};
        legal_fn[0] = 6'b000000;
        legal_fn[1] = 6'b100000;
        legal_fn[2] = 6'b100010;
        legal_fn[3] = 6'b100100;
        legal_fn[4] = 6'b100101;
        legal_fn[5] = 6'b101010;

        vecs[0]  = '{"reset_lw", 1'b1, 6'b100011, 6'h00, 10'b0, 1'b0};
        vecs[1]  = '{"rtype_nop", 1'b0, 6'b000000, 6'h00, 10'b1001000010, 1'b0};
        vecs[2]  = '{"lw", 1'b0, 6'b100011, 6'h15, 10'b0111000000, 1'b0};
        vecs[3]  = '{"sw", 1'b0, 6'b101011, 6'h3f, 10'b0100100000, 1'b0};
        vecs[4]  = '{"beq", 1'b0, 6'b000100, 6'h00, 10'b0000010001, 1'b0};
        vecs[5]  = '{"j", 1'b0, 6'b000010, 6'h00, 10'b0000001000, 1'b0};
        vecs[6]  = '{"addi", 1'b0, 6'b001000, 6'h00, 10'b0101000000, 1'b0};
        vecs[7]  = '{"invalid_3f", 1'b0, 6'b111111, 6'h20, 10'b0, 1'b1};
        vecs[8]  = '{"rtype_slt", 1'b0, 6'b000000, 6'b101010,
                     10'b1001000010, 1'b0};
        vecs[9]  = '{"rtype_bad_fn", 1'b0, 6'b000000, 6'b001000,
                     ILL ? 10'b1000000010 : 10'b1001000010, ILL};
        vecs[10] = '{"reset_over_sw", 1'b1, 6'b101011, 6'h00, 10'b0, 1'b0};
        vecs[11] = '{"reset_release_lw", 1'b0, 6'b100011, 6'h00,
                     10'b0111000000, 1'b0};

        step(1'b1, 6'b100011, 6'h00);
        chk("reset_state", 10'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].op, vecs[i].fn);
            chk(vecs[i].nm, vecs[i].e, vecs[i].ei);
        end

        // Outputs hold while inputs move between edges
        step(1'b0, 6'b001000, 6'h00);
        opcode = 6'b000100;
        #3;
        chk("hold_addi", 10'b0101000000, 1'b0);
        @(posedge clk);
        #1;
        chk("next_beq", 10'b0000010001, 1'b0);

        // Back-to-back LW/SW then reset dominates a write opcode
        step(1'b0, 6'b100011, 6'h00);
        chk("seq_lw", 10'b0111000000, 1'b0);
        step(1'b0, 6'b101011, 6'h00);
        chk("seq_sw", 10'b0100100000, 1'b0);
        step(1'b1, 6'b000000, 6'h2a);
        chk("seq_reset_rtype", 10'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 9) == 0);
            op = ($urandom_range(0, 2) == 0) ? 6'($urandom)
                                             : rows[$urandom_range(0, 5)].op;
            fn = ($urandom_range(0, 1) == 0) ? 6'($urandom)
                                             : legal_fn[$urandom_range(0, 5)];
            m  = r ? 11'b0 : ref_model(op, fn);
            step(r, op, fn);
            chk($sformatf("rand%0d_op%b_fn%b", n, op, fn), m[9:0], m[10]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
